// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter sharing one RAM slave port: round-robin grant,
// burst-aware release, one idle cycle between owners and a stall watchdog.
module wb_ram_arbiter #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [aw-1:0]   m0_adr_i,
  input  logic [dw-1:0]   m0_dat_i,
  input  logic [dw/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [dw-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [aw-1:0]   m1_adr_i,
  input  logic [dw-1:0]   m1_dat_i,
  input  logic [dw/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [dw-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [aw-1:0]   s_adr_o,
  output logic [dw-1:0]   s_dat_o,
  output logic [dw/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [dw-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e        state_q;
  logic          last_q;
  logic [CW-1:0] cnt_q;

  logic gnt0, gnt1, term, fire, burst_end, release_now;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
    end else if (gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
    end
  end

  assign term        = s_ack_i | s_err_i;
  assign fire        = (TIMEOUT != 0) && s_stb_o && (cnt_q == CW'(TIMEOUT));
  assign burst_end   = (s_cti_o == 3'b000) || (s_cti_o == 3'b111);
  // s_cyc_o carries the owner's cyc, so it is low exactly when the owner drops out.
  assign release_now = !s_cyc_o || (term && burst_end) || fire;

  // A watchdog hit overrides the slave: the owner sees an error, never an ack.
  assign m0_ack_o  = gnt0 & s_ack_i & ~fire;
  assign m0_err_o  = gnt0 & (s_err_i | fire);
  assign m1_ack_o  = gnt1 & s_ack_i & ~fire;
  assign m1_err_o  = gnt1 & (s_err_i | fire);
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign grant_o   = {gnt1, gnt0};
  assign timeout_o = fire;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= GNT0;
            last_q  <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q <= GNT1;
            last_q  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (release_now) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (term) begin
            cnt_q <= '0;
          end else if (s_stb_o) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter (watchdog shortened to 4 cycles); inputs
// change 1 time unit after the rising edge, outputs are checked on the falling edge.
module tb_wb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic        s_ack_i, s_err_i;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, timeout_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o, grant_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter #(.dw(32), .aw(32), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
    m0_cti_i = 3'b000; m0_bte_i = 2'b00; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
    m1_cti_i = 3'b000; m1_bte_i = 2'b00; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
    sample();
    checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    checks++; if ({s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, timeout_o} !== 5'b0) begin failures++; $display("FAIL reset_outs: got %b want 00000", {s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, timeout_o}); end
    tick();
    clear_inputs();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100; m0_cti_i = 3'b000;
    sample();
    checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL single_latency: grant %b cyc %b want 00 0", grant_o, s_cyc_o); end
    checks++; if (s_adr_o !== 32'h0) begin failures++; $display("FAIL single_idle_adr: got %h want 0", s_adr_o); end
    tick();
    sample();
    checks++; if (grant_o !== 2'b01 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h100) begin failures++; $display("FAIL single_grant: grant %b cyc %b adr %h want 01 1 100", grant_o, s_cyc_o, s_adr_o); end
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
    sample();
    checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEADBEEF || m1_ack_o !== 1'b0) begin failures++; $display("FAIL single_ack: ack0 %b dat %h ack1 %b want 1 deadbeef 0", m0_ack_o, m0_dat_o, m1_ack_o); end
    tick();
    clear_inputs();
    sample();
    checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL single_release: grant %b cyc %b want 00 0", grant_o, s_cyc_o); end
    $display("test_single_read done");
  endtask

  task automatic test_tie_from_reset();
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'hA0; m0_cti_i = 3'b111;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'hB0; m1_cti_i = 3'b000;
    tick();
    s_ack_i = 1'b1;
    sample();
    checks++; if (grant_o !== 2'b01 || s_adr_o !== 32'hA0) begin failures++; $display("FAIL tie_first: grant %b adr %h want 01 a0", grant_o, s_adr_o); end
    checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL tie_ack: ack0 %b ack1 %b want 1 0", m0_ack_o, m1_ack_o); end
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    sample();
    checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL tie_gap: grant %b cyc %b want 00 0", grant_o, s_cyc_o); end
    tick();
    s_ack_i = 1'b1;
    sample();
    checks++; if (grant_o !== 2'b10 || s_adr_o !== 32'hB0 || m1_ack_o !== 1'b1) begin failures++; $display("FAIL tie_second: grant %b adr %h ack1 %b want 10 b0 1", grant_o, s_adr_o, m1_ack_o); end
    tick();
    clear_inputs();
    $display("test_tie_from_reset done");
  endtask

  task automatic test_burst();
    logic [2:0] ctis [4];
    ctis[0] = 3'b010; ctis[1] = 3'b010; ctis[2] = 3'b010; ctis[3] = 3'b111;
    tick();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010; m1_adr_i = 32'h200;
    for (int b = 0; b < 4; b++) begin
      tick();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b000; m0_adr_i = 32'h300;
      m1_cti_i = ctis[b]; s_ack_i = 1'b1; s_dat_i = 32'h1000 + b;
      sample();
      checks++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL burst_beat%0d: grant %b ack1 %b ack0 %b want 10 1 0", b, grant_o, m1_ack_o, m0_ack_o); end
      checks++; if (m0_dat_o !== 32'h1000 + b) begin failures++; $display("FAIL burst_bcast%0d: got %h want %h", b, m0_dat_o, 32'h1000 + b); end
    end
    tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    sample();
    checks++; if (grant_o !== 2'b00 || m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL burst_gap: grant %b ack0 %b ack1 %b want 00 0 0", grant_o, m0_ack_o, m1_ack_o); end
    tick();
    s_ack_i = 1'b0;
    sample();
    checks++; if (grant_o !== 2'b01 || s_adr_o !== 32'h300) begin failures++; $display("FAIL burst_handover: grant %b adr %h want 01 300", grant_o, s_adr_o); end
    tick();
    s_ack_i = 1'b1;
    sample();
    checks++; if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL burst_m0_ack: got %b want 1", m0_ack_o); end
    tick();
    clear_inputs();
    $display("test_burst done");
  endtask

  task automatic test_timeout();
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b010;
    for (int c = 1; c <= 5; c++) begin
      tick();
      sample();
      if (c < 5) begin
        checks++; if (m0_err_o !== 1'b0 || timeout_o !== 1'b0 || grant_o !== 2'b01) begin failures++; $display("FAIL wdog_early%0d: err %b to %b grant %b want 0 0 01", c, m0_err_o, timeout_o, grant_o); end
      end else begin
        checks++; if (m0_err_o !== 1'b1 || timeout_o !== 1'b1 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL wdog_fire: err %b to %b ack %b want 1 1 0", m0_err_o, timeout_o, m0_ack_o); end
      end
    end
    tick();
    sample();
    checks++; if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || timeout_o !== 1'b0) begin failures++; $display("FAIL wdog_release: cyc %b grant %b to %b want 0 00 0", s_cyc_o, grant_o, timeout_o); end
    tick();
    clear_inputs();
    tick();
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_burst();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010;
    tick();
    s_ack_i = 1'b1;
    sample();
    checks++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1) begin failures++; $display("FAIL rstmid_beat1: grant %b ack1 %b want 10 1", grant_o, m1_ack_o); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({grant_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_ack_o, timeout_o} !== 8'b0) begin failures++; $display("FAIL rstmid_async: got %b want 00000000", {grant_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o, m0_ack_o, timeout_o}); end
    tick();
    clear_inputs();
    tick();
    rst_n = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b000;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b000;
    tick();
    sample();
    checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL rstmid_tie: grant %b want 01", grant_o); end
    tick();
    clear_inputs();
    tick();
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_slave_err();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_cti_i = 3'b000;
    m1_adr_i = 32'h44; m1_dat_i = 32'h12345678; m1_sel_i = 4'hF;
    tick();
    s_err_i = 1'b1;
    sample();
    checks++; if (grant_o !== 2'b10 || s_we_o !== 1'b1 || s_dat_o !== 32'h12345678 || s_sel_o !== 4'hF) begin failures++; $display("FAIL err_mux: grant %b we %b dat %h sel %h want 10 1 12345678 f", grant_o, s_we_o, s_dat_o, s_sel_o); end
    checks++; if (m1_err_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin failures++; $display("FAIL err_route: err1 %b ack1 %b err0 %b want 1 0 0", m1_err_o, m1_ack_o, m0_err_o); end
    tick();
    s_err_i = 1'b0;
    sample();
    checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL err_release: grant %b cyc %b want 00 0", grant_o, s_cyc_o); end
    tick();
    clear_inputs();
    $display("test_slave_err done");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_from_reset();
    test_burst();
    test_timeout();
    test_reset_mid_burst();
    test_slave_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
